// File: rtl/ddr2_init_pkg.sv
// Shared types and constants for the DDR2 power-up initialization sequencer.
package ddr2_init_pkg;

    // Sequencer phases. A phase is entered when its command (or cke rise)
    // issues, and it is left when that command's spacing has elapsed.
    typedef enum logic [3:0] {
        StCkeLow,
        StWaitXpr,
        StPrea1,
        StEmr2,
        StEmr3,
        StEmr1Dll,
        StMrDllRst,
        StPrea2,
        StRef1,
        StRef2,
        StMrRun,
        StEmr1OcdDef,
        StEmr1OcdExit,
        StWaitDll,
        StDone
    } state_t;

    // Command encodings as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DESELECT = 4'b1111;
    localparam logic [3:0] CMD_NOP      = 4'b0111;
    localparam logic [3:0] CMD_PREA     = 4'b0010;
    localparam logic [3:0] CMD_REF      = 4'b0001;
    localparam logic [3:0] CMD_MRS      = 4'b0000;

    // Mode-register bank selects
    localparam logic [1:0] BA_MR   = 2'd0;
    localparam logic [1:0] BA_EMR1 = 2'd1;
    localparam logic [1:0] BA_EMR2 = 2'd2;
    localparam logic [1:0] BA_EMR3 = 2'd3;

    // Address bit positions with special meaning
    localparam int unsigned A8_DLL_RST = 8;
    localparam int unsigned A10_AP     = 10;
    localparam int unsigned OCD_LSB    = 7;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr2_init_seq_if.sv
// Command/address bundle driven by the init sequencer toward the DIMM mux.
interface ddr2_init_seq_if #(
    parameter int unsigned BA_WIDTH   = 3,
    parameter int unsigned ADDR_WIDTH = 14
);
    logic                  cke;
    logic                  cs_n;
    logic                  ras_n;
    logic                  cas_n;
    logic                  we_n;
    logic [BA_WIDTH-1:0]   ba;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  odt;
    logic                  init_done;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt, init_done
    );

    modport slave (
        input cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt, init_done
    );
endinterface

// File: rtl/ddr2_init_timer.sv
// Loadable down-counter with a zero flag; saturates at 0.
module ddr2_init_timer #(
    parameter int unsigned     Width    = 8,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    output logic             o_zero
);
    logic [Width-1:0] r_count;

    // Load has priority over the free-running decrement.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= ResetVal;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - Width'(1);
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/ddr2_init_seq.sv
// DDR2 power-up initialization sequencer. Owns the command/address bus from
// reset until init_done, then parks it at NOP.
module ddr2_init_seq
    import ddr2_init_pkg::*;
#(
    parameter int unsigned           BA_WIDTH   = 3,
    parameter int unsigned           ADDR_WIDTH = 14,
    parameter int unsigned           T_CKE_LOW  = 40000,
    parameter int unsigned           T_XPR      = 80,
    parameter int unsigned           T_RP       = 3,
    parameter int unsigned           T_MRD      = 2,
    parameter int unsigned           T_RFC      = 26,
    parameter int unsigned           T_DLLK     = 200,
    parameter logic [ADDR_WIDTH-1:0] MR_VAL     = 'h0432,
    parameter logic [ADDR_WIDTH-1:0] EMR1_VAL   = 'h0004
) (
    input logic             i_clk,
    input logic             i_rst_n,
    ddr2_init_seq_if.master o_dram
);
    // Wait timer also holds T_CKE_LOW itself (reset value), hence the +1.
    localparam int unsigned WAIT_MAX = max_u(max_u(max_u(T_CKE_LOW, T_XPR), max_u(T_RP, T_MRD)),
                                             T_RFC);
    localparam int unsigned WAIT_W   = max_u($clog2(WAIT_MAX + 1), 1);
    localparam int unsigned DLL_W    = max_u($clog2(T_DLLK + 1), 1);

    // Timers are loaded with T-1 at the issuing edge so the zero flag is seen
    // exactly T edges later.
    localparam logic [WAIT_W-1:0] LD_XPR = WAIT_W'(T_XPR - 1);
    localparam logic [WAIT_W-1:0] LD_RP  = WAIT_W'(T_RP - 1);
    localparam logic [WAIT_W-1:0] LD_MRD = WAIT_W'(T_MRD - 1);
    localparam logic [WAIT_W-1:0] LD_RFC = WAIT_W'(T_RFC - 1);
    localparam logic [DLL_W-1:0]  LD_DLL = DLL_W'(T_DLLK - 1);

    localparam logic [ADDR_WIDTH-1:0] BIT_A0    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] BIT_A8    = ADDR_WIDTH'(1) << A8_DLL_RST;
    localparam logic [ADDR_WIDTH-1:0] OCD_MASK  = ADDR_WIDTH'(7) << OCD_LSB;
    localparam logic [ADDR_WIDTH-1:0] ADDR_PREA = ADDR_WIDTH'(1) << A10_AP;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MR_DLLRST = MR_VAL | BIT_A8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MR_RUN    = MR_VAL & ~BIT_A8;
    // DLL enable (A0=0) and OCD field cleared; OCD default sets A9:7 on top.
    localparam logic [ADDR_WIDTH-1:0] ADDR_EMR1_BASE = EMR1_VAL & ~(OCD_MASK | BIT_A0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_EMR1_OCD  = ADDR_EMR1_BASE | OCD_MASK;

    state_t                r_state;
    logic                  r_cke;
    logic [3:0]            r_cmd;
    logic [BA_WIDTH-1:0]   r_ba;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_done;

    logic                  w_wait_zero;
    logic                  w_dll_zero;
    logic                  w_wait_load;
    logic                  w_has_next;
    logic [WAIT_W-1:0]     w_wait_val;
    logic                  w_dll_load;

    // Spacing to load when the current phase's wait expires and the next
    // command issues.
    always_comb begin
        w_has_next = 1'b1;
        w_wait_val = '0;
        w_dll_load = 1'b0;
        unique case (r_state)
            StCkeLow:     w_wait_val = LD_XPR;
            StWaitXpr:    w_wait_val = LD_RP;
            StPrea1:      w_wait_val = LD_MRD;
            StEmr2:       w_wait_val = LD_MRD;
            StEmr3:       w_wait_val = LD_MRD;
            StEmr1Dll: begin
                w_wait_val = LD_MRD;
                w_dll_load = w_wait_zero;
            end
            StMrDllRst:   w_wait_val = LD_RP;
            StPrea2:      w_wait_val = LD_RFC;
            StRef1:       w_wait_val = LD_RFC;
            StRef2:       w_wait_val = LD_MRD;
            StMrRun:      w_wait_val = LD_MRD;
            StEmr1OcdDef: w_wait_val = LD_MRD;
            default:      w_has_next = 1'b0;
        endcase
        w_wait_load = w_wait_zero && w_has_next;
    end

    ddr2_init_timer #(
        .Width    (WAIT_W),
        .ResetVal (WAIT_W'(T_CKE_LOW))
    ) u_wait_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_wait_load),
        .i_load_val (w_wait_val),
        .o_zero     (w_wait_zero)
    );

    ddr2_init_timer #(
        .Width    (DLL_W),
        .ResetVal ('0)
    ) u_dll_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_dll_load),
        .i_load_val (LD_DLL),
        .o_zero     (w_dll_zero)
    );

    // Sequencer FSM with registered bus outputs; every command lasts one cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StCkeLow;
            r_cke   <= 1'b0;
            r_cmd   <= CMD_DESELECT;
            r_ba    <= '0;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_cmd  <= CMD_NOP;
            r_ba   <= '0;
            r_addr <= '0;
            case (r_state)
                StCkeLow: begin
                    if (w_wait_zero) begin
                        r_cke   <= 1'b1;
                        r_state <= StWaitXpr;
                    end else begin
                        r_cmd <= CMD_DESELECT;
                    end
                end
                StWaitXpr: if (w_wait_zero) begin
                    r_cmd   <= CMD_PREA;
                    r_addr  <= ADDR_PREA;
                    r_state <= StPrea1;
                end
                StPrea1: if (w_wait_zero) begin
                    r_cmd   <= CMD_MRS;
                    r_ba    <= BA_WIDTH'(BA_EMR2);
                    r_state <= StEmr2;
                end
                StEmr2: if (w_wait_zero) begin
                    r_cmd   <= CMD_MRS;
                    r_ba    <= BA_WIDTH'(BA_EMR3);
                    r_state <= StEmr3;
                end
                StEmr3: if (w_wait_zero) begin
                    r_cmd   <= CMD_MRS;
                    r_ba    <= BA_WIDTH'(BA_EMR1);
                    r_addr  <= ADDR_EMR1_BASE;
                    r_state <= StEmr1Dll;
                end
                StEmr1Dll: if (w_wait_zero) begin
                    r_cmd   <= CMD_MRS;
                    r_ba    <= BA_WIDTH'(BA_MR);
                    r_addr  <= ADDR_MR_DLLRST;
                    r_state <= StMrDllRst;
                end
                StMrDllRst: if (w_wait_zero) begin
                    r_cmd   <= CMD_PREA;
                    r_addr  <= ADDR_PREA;
                    r_state <= StPrea2;
                end
                StPrea2: if (w_wait_zero) begin
                    r_cmd   <= CMD_REF;
                    r_state <= StRef1;
                end
                StRef1: if (w_wait_zero) begin
                    r_cmd   <= CMD_REF;
                    r_state <= StRef2;
                end
                StRef2: if (w_wait_zero) begin
                    r_cmd   <= CMD_MRS;
                    r_ba    <= BA_WIDTH'(BA_MR);
                    r_addr  <= ADDR_MR_RUN;
                    r_state <= StMrRun;
                end
                StMrRun: if (w_wait_zero) begin
                    r_cmd   <= CMD_MRS;
                    r_ba    <= BA_WIDTH'(BA_EMR1);
                    r_addr  <= ADDR_EMR1_OCD;
                    r_state <= StEmr1OcdDef;
                end
                StEmr1OcdDef: if (w_wait_zero) begin
                    r_cmd   <= CMD_MRS;
                    r_ba    <= BA_WIDTH'(BA_EMR1);
                    r_addr  <= ADDR_EMR1_BASE;
                    r_state <= StEmr1OcdExit;
                end
                // DLL lock may already be satisfied: finish with no extra cycle.
                StEmr1OcdExit: if (w_wait_zero) begin
                    if (w_dll_zero) begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_state <= StWaitDll;
                    end
                end
                StWaitDll: if (w_dll_zero) begin
                    r_done  <= 1'b1;
                    r_state <= StDone;
                end
                StDone: begin
                end
                default: r_state <= StCkeLow;
            endcase
        end
    end

    assign o_dram.cke       = r_cke;
    assign o_dram.cs_n      = r_cmd[3];
    assign o_dram.ras_n     = r_cmd[2];
    assign o_dram.cas_n     = r_cmd[1];
    assign o_dram.we_n      = r_cmd[0];
    assign o_dram.ba        = r_ba;
    assign o_dram.addr      = r_addr;
    assign o_dram.odt       = 1'b0;
    assign o_dram.init_done = r_done;
endmodule

// File: tb/tb_ddr2_init_seq.sv
// Directed bench for ddr2_init_seq: three parameterisations traced per cycle
// and compared against hand-computed command tables.
module tb_ddr2_init_seq;
    localparam logic [3:0] DES = 4'b1111;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] RF  = 4'b0001;
    localparam logic [3:0] MRS = 4'b0000;
    localparam int NCYC = 80;

    typedef struct {
        int         dut;
        int         cyc;
        logic       cke;
        logic       done;
        logic [3:0] cmd;
        logic [2:0] ba;
        logic [13:0] addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mon_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   viol = 0;
    vec_t vecs[$];
    // {cke, done, cmd[3:0], ba[2:0], addr[13:0]}
    logic [22:0] trace [3][NCYC];

    always #5 clk = ~clk;

    ddr2_init_seq_if #(.BA_WIDTH(3), .ADDR_WIDTH(14)) dram_a ();
    ddr2_init_seq_if #(.BA_WIDTH(3), .ADDR_WIDTH(14)) dram_b ();
    ddr2_init_seq_if #(.BA_WIDTH(3), .ADDR_WIDTH(14)) dram_c ();

    // A: baseline timing with the field-check mode values
    ddr2_init_seq #(
        .BA_WIDTH(3), .ADDR_WIDTH(14), .T_CKE_LOW(10), .T_XPR(4), .T_RP(3), .T_MRD(2),
        .T_RFC(8), .T_DLLK(20), .MR_VAL(14'h0432), .EMR1_VAL(14'h0045)
    ) u_dut_a (.i_clk(clk), .i_rst_n(rst_n), .o_dram(dram_a));

    // B: DLL lock dominates completion
    ddr2_init_seq #(
        .BA_WIDTH(3), .ADDR_WIDTH(14), .T_CKE_LOW(10), .T_XPR(4), .T_RP(3), .T_MRD(2),
        .T_RFC(8), .T_DLLK(40), .MR_VAL(14'h0432), .EMR1_VAL(14'h0004)
    ) u_dut_b (.i_clk(clk), .i_rst_n(rst_n), .o_dram(dram_b));

    // C: all minimum timings
    ddr2_init_seq #(
        .BA_WIDTH(3), .ADDR_WIDTH(14), .T_CKE_LOW(1), .T_XPR(1), .T_RP(1), .T_MRD(1),
        .T_RFC(1), .T_DLLK(1), .MR_VAL(14'h0432), .EMR1_VAL(14'h0045)
    ) u_dut_c (.i_clk(clk), .i_rst_n(rst_n), .o_dram(dram_c));

    function automatic logic bad_bus(input logic cke, input logic cs_n, input logic [3:0] cmd,
                                     input logic odt, input logic done);
        return (!cke && !cs_n) || odt || (done && (cmd != NOP || !cke));
    endfunction

    // Protocol monitor: no selected command while cke=0, odt never set,
    // bus parked at NOP with cke=1 once done.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bad_bus(dram_a.cke, dram_a.cs_n,
                        {dram_a.cs_n, dram_a.ras_n, dram_a.cas_n, dram_a.we_n},
                        dram_a.odt, dram_a.init_done)) viol++;
            if (bad_bus(dram_b.cke, dram_b.cs_n,
                        {dram_b.cs_n, dram_b.ras_n, dram_b.cas_n, dram_b.we_n},
                        dram_b.odt, dram_b.init_done)) viol++;
            if (bad_bus(dram_c.cke, dram_c.cs_n,
                        {dram_c.cs_n, dram_c.ras_n, dram_c.cas_n, dram_c.we_n},
                        dram_c.odt, dram_c.init_done)) viol++;
        end
    end

    function automatic logic [22:0] snap_a();
        return {dram_a.cke, dram_a.init_done, dram_a.cs_n, dram_a.ras_n, dram_a.cas_n,
                dram_a.we_n, dram_a.ba, dram_a.addr};
    endfunction

    function automatic logic [22:0] snap_b();
        return {dram_b.cke, dram_b.init_done, dram_b.cs_n, dram_b.ras_n, dram_b.cas_n,
                dram_b.we_n, dram_b.ba, dram_b.addr};
    endfunction

    function automatic logic [22:0] snap_c();
        return {dram_c.cke, dram_c.init_done, dram_c.cs_n, dram_c.ras_n, dram_c.cas_n,
                dram_c.we_n, dram_c.ba, dram_c.addr};
    endfunction

    function automatic void add(input int d, input int c, input logic ke, input logic dn,
                                input logic [3:0] cmd, input logic [2:0] ba,
                                input logic [13:0] ad);
        vecs.push_back('{d, c, ke, dn, cmd, ba, ad});
    endfunction

    task automatic chk(input string name, input logic [22:0] got, input logic [22:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Sample cycles 0..NCYC-1 after reset release (rst_n already 1).
    task automatic run_trace();
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            trace[0][c] = snap_a();
            trace[1][c] = snap_b();
            trace[2][c] = snap_c();
        end
    endtask

    task automatic check_tables(input string tag);
        int cnt;
        int bad;
        foreach (vecs[i]) begin
            chk($sformatf("%s dut%0d cyc%0d", tag, vecs[i].dut, vecs[i].cyc),
                trace[vecs[i].dut][vecs[i].cyc],
                {vecs[i].cke, vecs[i].done, vecs[i].cmd, vecs[i].ba, vecs[i].addr});
        end
        for (int d = 0; d < 3; d++) begin
            cnt = 0;
            for (int c = 0; c < NCYC; c++) begin
                if (!trace[d][c][20] && trace[d][c][20:17] != NOP) cnt++;
            end
            chk_int($sformatf("%s dut%0d command count", tag, d), cnt, 11);
        end
        bad = 0;
        for (int c = 49; c < 63; c++) begin
            if (trace[1][c][20:17] != NOP || !trace[1][c][22]) bad++;
        end
        chk_int($sformatf("%s dutB NOP hold 49..62", tag), bad, 0);
    endtask

    localparam logic [22:0] RST_PACK = {1'b0, 1'b0, DES, 3'd0, 14'd0};

    initial begin
        // A: baseline
        add(0, 0,  1'b0, 1'b0, DES, 3'd0, 14'h0000);
        add(0, 9,  1'b0, 1'b0, DES, 3'd0, 14'h0000);
        add(0, 10, 1'b1, 1'b0, NOP, 3'd0, 14'h0000);
        add(0, 13, 1'b1, 1'b0, NOP, 3'd0, 14'h0000);
        add(0, 14, 1'b1, 1'b0, PRE, 3'd0, 14'h0400);
        add(0, 17, 1'b1, 1'b0, MRS, 3'd2, 14'h0000);
        add(0, 19, 1'b1, 1'b0, MRS, 3'd3, 14'h0000);
        add(0, 21, 1'b1, 1'b0, MRS, 3'd1, 14'h0044);
        add(0, 23, 1'b1, 1'b0, MRS, 3'd0, 14'h0532);
        add(0, 25, 1'b1, 1'b0, PRE, 3'd0, 14'h0400);
        add(0, 28, 1'b1, 1'b0, RF,  3'd0, 14'h0000);
        add(0, 36, 1'b1, 1'b0, RF,  3'd0, 14'h0000);
        add(0, 44, 1'b1, 1'b0, MRS, 3'd0, 14'h0432);
        add(0, 46, 1'b1, 1'b0, MRS, 3'd1, 14'h03C4);
        add(0, 48, 1'b1, 1'b0, MRS, 3'd1, 14'h0044);
        add(0, 49, 1'b1, 1'b0, NOP, 3'd0, 14'h0000);
        add(0, 50, 1'b1, 1'b1, NOP, 3'd0, 14'h0000);
        add(0, 79, 1'b1, 1'b1, NOP, 3'd0, 14'h0000);
        // B: DLL-dominated
        add(1, 23, 1'b1, 1'b0, MRS, 3'd0, 14'h0532);
        add(1, 48, 1'b1, 1'b0, MRS, 3'd1, 14'h0004);
        add(1, 50, 1'b1, 1'b0, NOP, 3'd0, 14'h0000);
        add(1, 62, 1'b1, 1'b0, NOP, 3'd0, 14'h0000);
        add(1, 63, 1'b1, 1'b1, NOP, 3'd0, 14'h0000);
        // C: minimum timings, back-to-back
        add(2, 0,  1'b0, 1'b0, DES, 3'd0, 14'h0000);
        add(2, 1,  1'b1, 1'b0, NOP, 3'd0, 14'h0000);
        add(2, 2,  1'b1, 1'b0, PRE, 3'd0, 14'h0400);
        add(2, 3,  1'b1, 1'b0, MRS, 3'd2, 14'h0000);
        add(2, 4,  1'b1, 1'b0, MRS, 3'd3, 14'h0000);
        add(2, 5,  1'b1, 1'b0, MRS, 3'd1, 14'h0044);
        add(2, 6,  1'b1, 1'b0, MRS, 3'd0, 14'h0532);
        add(2, 7,  1'b1, 1'b0, PRE, 3'd0, 14'h0400);
        add(2, 8,  1'b1, 1'b0, RF,  3'd0, 14'h0000);
        add(2, 9,  1'b1, 1'b0, RF,  3'd0, 14'h0000);
        add(2, 10, 1'b1, 1'b0, MRS, 3'd0, 14'h0432);
        add(2, 11, 1'b1, 1'b0, MRS, 3'd1, 14'h03C4);
        add(2, 12, 1'b1, 1'b0, MRS, 3'd1, 14'h0044);
        add(2, 13, 1'b1, 1'b1, NOP, 3'd0, 14'h0000);

        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("reset state A", snap_a(), RST_PACK);

        rst_n = 1'b1;
        run_trace();
        check_tables("first");

        // Reset after done: all outputs back to reset values on the next edge
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset after done A", snap_a(), RST_PACK);
        chk("reset after done B", snap_b(), RST_PACK);
        chk("reset after done C", snap_c(), RST_PACK);

        // One-cycle reset at cycle 30, then the whole sequence must replay
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid-sequence reset A", snap_a(), RST_PACK);
        chk("mid-sequence reset B", snap_b(), RST_PACK);
        rst_n = 1'b1;
        run_trace();
        check_tables("replay");

        chk_int("protocol monitor violations", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr2_init_seq.md
Name: ddr2_init_seq

Overview:
- JEDEC DDR2 power-up initialization sequencer in the controller, directly upstream of the DIMM command/address bus.
- Drives cke/cs_n/ras_n/cas_n/we_n/ba/addr/odt from reset until initialization completes, then asserts init_done so the main scheduler takes the bus.
- Replaces the simulation-only init_done force in the DRAM model, so the full power-up sequence is exercised.

Parameters:
- BA_WIDTH, `DRAM_BA_WIDTH: bank address width.
- ADDR_WIDTH, `DRAM_ADDR_WIDTH: row/mode address width (≥13).
- T_CKE_LOW, 40000: cycles cke is held low after reset (200 us).
- T_XPR, 80: cycles from cke rise to the first PREA (400 ns).
- T_RP, 3: cycles from PREA to the next command.
- T_MRD, 2: cycles from MRS/EMRS to the next command.
- T_RFC, 26: cycles from REF to the next command.
- T_DLLK, 200: cycles from MR(DLL reset) until init_done may assert.
- MR_VAL, 0x0432: MR contents. A8 is overridden by the sequencer.
- EMR1_VAL, 0x0004: EMR1 contents. A9:7 is overridden; A0 is forced to 0 (DLL enable).
- All T_* parameters must be ≥1.

Ports:
- clk  in  1  controller clock, equal to DRAM ck.
- rst_n  in  1  synchronous, active-low reset.
- cke  out  1  clock enable.
- cs_n  out  1  chip select.
- ras_n  out  1  row address strobe.
- cas_n  out  1  column address strobe.
- we_n  out  1  write enable.
- ba  out  BA_WIDTH  bank address, selects the mode register during MRS.
- addr  out  ADDR_WIDTH  address / mode register value (A10 = 1 for PREA).
- odt  out  1  on-die termination, always 0.
- init_done  out  1  sticky high once the sequence finishes.

Behaviour:
- Clocking: one clock; reset is synchronous and active-low. All outputs are registered.
- Reset values: cke=0, cs_n=1, ras_n=1, cas_n=1, we_n=1, ba=0, addr=0, odt=0, init_done=0.
- Reset asserted at any point, including mid-sequence or after done: every output returns to its reset value on the next edge, and the sequence restarts from CKE_LOW.
- Command encodings as {cs_n, ras_n, cas_n, we_n}:
  - DESELECT = 1xxx (driven as 1111).
  - NOP = 0111.
  - PREA = 0010, with addr[10]=1.
  - REF = 0001.
  - MRS = 0000.
- Each command is driven for exactly one cycle. NOP is driven until the next command.
- Command spacing: a command at cycle n is followed by the next command at cycle n+T_x, where T_x belongs to the issued command.
- Timing counts are measured from cycle 0, the first edge with rst_n=1.
- States and timing, in order:
  - CKE_LOW: DESELECT, cke=0. At cycle T_CKE_LOW, cke becomes 1 and NOP is driven.
  - WAIT_XPR: after T_XPR cycles, go to PREA1.
  - PREA1: issue PREA, wait T_RP.
  - EMR2: MRS with ba=2, addr=0; wait T_MRD.
  - EMR3: MRS with ba=3, addr=0; wait T_MRD.
  - EMR1_DLL: MRS with ba=1, addr=EMR1_VAL with A9:7=000 and A0=0; wait T_MRD.
  - MR_DLLRST: MRS with ba=0, addr=MR_VAL with A8=1; wait T_MRD. Issuing this command loads the DLL counter with T_DLLK.
  - PREA2: issue PREA, wait T_RP.
  - REF1, REF2: issue REF, wait T_RFC after each.
  - MR_RUN: MRS with ba=0, addr=MR_VAL with A8=0; wait T_MRD.
  - EMR1_OCDDEF: MRS with ba=1, A9:7=111; wait T_MRD.
  - EMR1_OCDEXIT: MRS with ba=1, A9:7=000; wait T_MRD.
  - WAIT_DLL: hold until the DLL counter reaches 0. It may already be 0, in which case there is zero extra delay.
  - DONE: init_done=1, NOP, cke=1, held until reset.
- Counters:
  - One down-counter is shared for inter-command waits, sized by clog2 of the largest T.
  - An independent DLL counter decrements every cycle after it is loaded and saturates at 0.
- Bus ownership: outputs are stable NOP while init_done=1. The downstream mux switches on init_done.

Decomposition:
- Package ddr2_init_pkg holds:
  - the state enum;
  - the 4-bit command encodings (DESELECT, NOP, PREA, REF, MRS);
  - mode-register bank selects MR=0, EMR1=1, EMR2=2, EMR3=3;
  - the bit-position constants A8_DLL_RST, A10_AP and OCD_LSB=7.
- Sub-module ddr2_init_timer (loadable down-counter with a zero flag) is instanced twice: once for waits, once for DLL.

Test Plan:
- Baseline timing, with T_CKE_LOW=10, T_XPR=4, T_RP=3, T_MRD=2, T_RFC=8, T_DLLK=20:
  - cke rises at cycle 10.
  - Commands appear at these cycles: PREA 14, EMR2 17, EMR3 19, EMR1 21, MR(A8=1) 23, PREA 25, REF 28, REF 36, MR(A8=0) 44, EMR1 OCD=111 46, EMR1 OCD=000 48.
  - init_done rises at cycle 50.
- DLL-dominated completion: same parameters with T_DLLK=40 → init_done rises at cycle 63. Bus holds NOP during cycles 50–62.
- Field check: MR_VAL=0x0432, EMR1_VAL=0x0045 →
  - MR_DLLRST addr=0x0532;
  - MR_RUN addr=0x0432;
  - EMR1_DLL addr=0x0044;
  - OCDDEF addr=0x03C4;
  - PREA addr[10]=1 with ba=0.
- Reset mid-sequence: rst_n=0 for one cycle at cycle 30 → next edge returns cke=0, cs_n=1, init_done=0. The full sequence replays with identical offsets from the new reset release.
- Minimum timings, all T_*=1 → commands issue on consecutive cycles with no gaps. init_done asserts one cycle after the last EMR1.
- Pre-done protocol check: assertion monitor proves no REF/MRS/PREA issues while cke=0, and cs_n=1 throughout CKE_LOW.
